// File: rtl/dec_to_ieee_if.sv
// rtl/dec_to_ieee_if.sv - handshake bundle between a producer/consumer and dec_to_ieee
//
// Signals:
//   in_dec       producer -> block   signed value scaled by 10
//   in_valid     producer -> block   in_dec valid this cycle
//   in_ready     block -> producer   block accepts in_dec this cycle
//   out_ieee     block -> consumer   single-precision encoding of in_dec/10
//   out_inexact  block -> consumer   result was rounded
//   out_valid    block -> consumer   out_ieee/out_inexact valid
//   out_ready    consumer -> block   consumer takes the result this cycle
// Modports: master (testbench / surrounding logic), slave (dec_to_ieee).

interface dec_to_ieee_if;
    logic [31:0] in_dec;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_ieee;
    logic        out_inexact;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output in_dec, in_valid, out_ready,
        input  in_ready, out_ieee, out_inexact, out_valid
    );

    modport slave (
        input  in_dec, in_valid, out_ready,
        output in_ready, out_ieee, out_inexact, out_valid
    );
endinterface

// File: rtl/dec_to_ieee.sv
// rtl/dec_to_ieee.sv - converts a tenths-scaled signed integer to IEEE-754 single precision
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-low reset
//   bus   dec_to_ieee_if.slave: in_dec/in_valid/in_ready input handshake,
//         out_ieee/out_inexact/out_valid/out_ready output handshake
//
// Operation: IDLE accepts a value, DIV performs 60 restoring-division steps by 10
// (32 magnitude bits followed by 28 fraction bits), NORM finds the leading one,
// ROUND applies round-to-nearest-even, DONE holds the result until taken.

module dec_to_ieee (
    input  logic         clk,
    input  logic         rst,
    dec_to_ieee_if.slave bus
);

    typedef enum logic [2:0] {IDLE, DIV, NORM, ROUND, DONE} state_t;

    state_t      state;
    state_t      state_nxt;

    logic        sign;
    logic [31:0] mag_sr;
    logic [3:0]  rem;
    logic [59:0] quo;
    logic [5:0]  cnt;

    logic [23:0] sig;
    logic        guard;
    logic        sticky;
    logic        zero;
    logic [7:0]  exp_b;

    logic [31:0] ieee_q;
    logic        inexact_q;

    // Division step: bring down the next dividend bit. Once the 32 magnitude
    // bits have been shifted out, mag_sr supplies zeros for the fraction bits.
    logic [4:0]  rem_sh;
    logic        rem_ge;
    logic [3:0]  rem_diff;
    logic [3:0]  rem_nxt;

    always_comb begin
        rem_sh   = {rem, mag_sr[31]};
        rem_ge   = (rem_sh >= 5'd10);
        // The difference is below 10 whenever it is used, so 4 bits suffice.
        rem_diff = rem_sh[3:0] - 4'd10;
        rem_nxt  = rem_ge ? rem_diff : rem_sh[3:0];
    end

    // Normalisation: shift the leading one up to bit 59 so that the
    // significand, guard and sticky fields sit at fixed positions. Bits
    // shifted in from below index 0 are zero.
    logic [5:0]  lead_pos;
    logic [59:0] quo_norm;
    logic [23:0] norm_sig;
    logic        norm_guard;
    logic        norm_sticky;
    logic [7:0]  norm_exp;

    always_comb begin
        lead_pos = 6'd0;
        for (int i = 0; i < 60; i++) begin
            if (quo[i]) begin
                lead_pos = 6'(i);
            end
        end
        quo_norm    = quo << (6'd59 - lead_pos);
        norm_sig    = quo_norm[59:36];
        norm_guard  = quo_norm[35];
        norm_sticky = (|quo_norm[34:0]) | (rem != 4'd0);
        // Unbiased exponent is lead_pos-28; add the bias of 127.
        norm_exp    = {2'b00, lead_pos} + 8'd99;
    end

    // Rounding: nearest-even; a carry out of the significand renormalises.
    logic        rnd_up;
    logic [24:0] rnd_sum;
    logic [22:0] rnd_frac;
    logic [7:0]  rnd_exp;

    always_comb begin
        rnd_up   = guard & (sticky | sig[0]);
        rnd_sum  = {1'b0, sig} + {24'd0, rnd_up};
        rnd_frac = rnd_sum[24] ? rnd_sum[23:1] : rnd_sum[22:0];
        rnd_exp  = exp_b + {7'd0, rnd_sum[24]};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = DIV;
            DIV:     if (cnt == 6'd59)  state_nxt = NORM;
            NORM:                       state_nxt = ROUND;
            ROUND:                      state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sign      <= 1'b0;
            mag_sr    <= 32'd0;
            rem       <= 4'd0;
            quo       <= 60'd0;
            cnt       <= 6'd0;
            sig       <= 24'd0;
            guard     <= 1'b0;
            sticky    <= 1'b0;
            zero      <= 1'b0;
            exp_b     <= 8'd0;
            ieee_q    <= 32'd0;
            inexact_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sign   <= bus.in_dec[31];
                        // -2^31 negates to itself, which is the correct
                        // unsigned magnitude 0x80000000.
                        mag_sr <= bus.in_dec[31] ? -bus.in_dec : bus.in_dec;
                        rem    <= 4'd0;
                        quo    <= 60'd0;
                        cnt    <= 6'd0;
                    end
                end
                DIV: begin
                    mag_sr <= {mag_sr[30:0], 1'b0};
                    rem    <= rem_nxt;
                    quo    <= {quo[58:0], rem_ge};
                    cnt    <= cnt + 6'd1;
                end
                NORM: begin
                    sig    <= norm_sig;
                    guard  <= norm_guard;
                    sticky <= norm_sticky;
                    exp_b  <= norm_exp;
                    zero   <= (quo == 60'd0);
                end
                ROUND: begin
                    if (zero) begin
                        ieee_q    <= 32'd0;
                        inexact_q <= 1'b0;
                    end else begin
                        ieee_q    <= {sign, rnd_exp, rnd_frac};
                        inexact_q <= guard | sticky;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.out_valid   = (state == DONE);
    assign bus.out_ieee    = ieee_q;
    assign bus.out_inexact = inexact_q;

endmodule

// File: doc/dec_to_ieee.md
DEC_TO_IEEE -- requirements
Module: dec_to_ieee

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-low (rst=0 at a clk rising edge resets the block).
REQ-003 in_dec  input  32  signed two's-complement value scaled by 10 (represents in_dec/10.0).
REQ-004 in_valid  input  1  in_dec is valid this cycle.
REQ-005 in_ready  output  1  block accepts in_dec this cycle.
REQ-006 out_ieee  output  32  IEEE-754 single-precision encoding of in_dec/10.0.
REQ-007 out_inexact  output  1  result was rounded (guard or sticky nonzero).
REQ-008 out_valid  output  1  out_ieee/out_inexact are valid.
REQ-009 out_ready  input  1  consumer takes the result this cycle.

Function
REQ-010 FSM states SHALL be IDLE, DIV, NORM, ROUND, DONE; reset state IDLE.
REQ-011 in_ready SHALL be 1 only in IDLE; input transfer = in_valid & in_ready at a rising edge.
REQ-012 On transfer: latch sign = in_dec[31], magnitude = |in_dec| as 32-bit unsigned (-2^31 -> 0x80000000), clear remainder/quotient, enter DIV.
REQ-013 DIV SHALL run exactly 60 cycles of restoring division by 10, one quotient bit per cycle, MSB first: 32 cycles shifting in magnitude bits, then 28 cycles shifting in zeros; result is a 60-bit quotient Q = floor(mag*2^28/10) and final remainder R.
REQ-014 NORM (1 cycle): locate leading one of Q at bit p; unbiased exponent = p-28; take 24-bit significand Q[p:p-23], guard = Q[p-24], sticky = OR(Q[p-25:0]) | (R!=0); bits below index 0 count as 0.
REQ-015 ROUND (1 cycle): round-to-nearest-even; increment significand when guard & (sticky | lsb); on significand carry-out, shift right 1 and exponent+1.
REQ-016 Biased exponent = unbiased+127; out_ieee = {sign, exp[7:0], significand[22:0]}; out_inexact = guard|sticky.
REQ-017 Magnitude 0 (Q=0): out_ieee SHALL be 32'h00000000 (positive zero, regardless of sign), out_inexact 0.
REQ-018 Input range (|x| from 0.1 to 214748364.8) needs no denormal, infinity or overflow handling; exponent range 123..154.
REQ-019 Latency fixed: transfer at edge E -> out_valid=1 after edge E+62, independent of data.
REQ-020 DONE: out_valid=1; out_ieee/out_inexact held stable until out_valid & out_ready at a rising edge, then IDLE (in_ready=1 next cycle).
REQ-021 out_ready ignored outside DONE; in_valid ignored outside IDLE; DONE with out_ready held 0 stalls indefinitely.
REQ-022 Back-to-back: minimum spacing between accepted inputs 64 cycles (62 + DONE handshake + IDLE).

Reset
REQ-023 rst=0 at any edge, including mid-DIV/NORM/ROUND/DONE, SHALL abort the operation and go to IDLE; the pending result is discarded.
REQ-024 Values after reset: in_ready=1, out_valid=0, out_ieee=32'h0, out_inexact=0, internal quotient/remainder/counter=0.
REQ-025 Reset SHALL have priority over in_valid and out_ready in the same cycle.

Verification
REQ-026 in_dec=11, then -22, then 33 -> out_ieee 32'h3F8CCCCD, 32'hC00CCCCD, 32'h40533333; inexact=1 each; out_valid exactly 62 edges after transfer.
REQ-027 in_dec=-35 -> 32'hC0600000, inexact=0; in_dec=70 -> 32'h40E00000, inexact=0; in_dec=9 -> 32'h3F666666, inexact=1.
REQ-028 in_dec=1 -> 32'h3DCCCCCD; in_dec=0 -> 32'h00000000, inexact=0; in_dec=-2147483648 -> 32'hCD4CCCCD, inexact=1; in_dec=2147483647 -> 32'h4D4CCCCD.
REQ-029 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_ieee stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-030 Reset mid-DIV (cycle 30) -> next cycle in_ready=1, out_valid=0, out_ieee=0; new in_dec=20 -> 32'h40000000 after 62 edges.
